// File: rtl/bios_loader_rom_if.sv
// Bus bundle for the field-loadable BIOS instruction store: byte loader
// handshake, control pulses, status and the CPU fetch port.
interface bios_loader_rom_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 5
);
    logic              load_start;
    logic              load_abort;
    logic              clear_req;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              busy;
    logic              load_done;
    logic [ADDR_W:0]   word_count;

    modport master (
        output load_start, load_abort, clear_req, byte_data, byte_valid, rd_addr,
        input  byte_ready, rd_data, busy, load_done, word_count
    );

    modport slave (
        input  load_start, load_abort, clear_req, byte_data, byte_valid, rd_addr,
        output byte_ready, rd_data, busy, load_done, word_count
    );
endinterface

// File: rtl/bios_loader_rom.sv
// Register-array instruction store for the i281 CPU, filled at run time from a
// byte stream (MSB byte first per word) and read combinationally by the fetch path.
module bios_loader_rom #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic               clk,
    input logic               rst,
    bios_loader_rom_if.slave  bus
);
    localparam int BPW    = WORD_W / 8;
    localparam int HOLD_W = (BPW > 1) ? (BPW - 1) * 8 : 8;
    localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              load_done_q, load_done_d;
    logic              busy_q, busy_d;
    logic              wr_en;
    logic              clr_all;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        byte_idx_d   = byte_idx_q;
        hold_d       = hold_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        wr_en        = 1'b0;
        clr_all      = 1'b0;
        // Held bytes sit above the incoming byte, so the first byte lands on top.
        wr_data      = WORD_W'({hold_q, bus.byte_data});

        case (state_q)
            LOAD: begin
                if (bus.load_abort) begin
                    state_d    = IDLE;
                    byte_idx_d = '0;
                    hold_d     = '0;
                end else if (bus.load_start) begin
                    waddr_d      = '0;
                    byte_idx_d   = '0;
                    hold_d       = '0;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                end else if (bus.byte_valid) begin
                    if (byte_idx_q < IDX_W'(BPW - 1)) begin
                        hold_d     = HOLD_W'({hold_q, bus.byte_data});
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end else begin
                        wr_en        = 1'b1;
                        waddr_d      = waddr_q + ADDR_W'(1);
                        word_count_d = word_count_q + (ADDR_W + 1)'(1);
                        byte_idx_d   = '0;
                        hold_d       = '0;
                        if (waddr_q == ADDR_W'(DEPTH - 1)) begin
                            state_d     = DONE;
                            load_done_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (bus.clear_req) begin
                    clr_all      = 1'b1;
                    load_done_d  = 1'b0;
                    word_count_d = '0;
                    state_d      = IDLE;
                end
                if (bus.load_start) begin
                    state_d      = LOAD;
                    waddr_d      = '0;
                    byte_idx_d   = '0;
                    hold_d       = '0;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                end
            end
        endcase

        busy_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            byte_idx_q   <= '0;
            hold_q       <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            byte_idx_q   <= byte_idx_d;
            hold_q       <= hold_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_q == ADDR_W'(i)) mem_q[i] <= wr_data;
            end
        end
    end

    // Addresses at or beyond DEPTH match no entry and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) rd_data = mem_q[i];
        end
    end

    assign bus.rd_data    = rd_data;
    assign bus.busy       = busy_q;
    assign bus.byte_ready = busy_q;
    assign bus.load_done  = load_done_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_bios_loader_rom.sv
// Directed bench for bios_loader_rom: loads, stalls, aborts, priorities,
// clears and asynchronous reset, with hand-computed expected values.
module tb_bios_loader_rom;
    localparam int WW = 16;
    localparam int DP = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bios_loader_rom_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

    bios_loader_rom #(.WORD_W(WW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [15:0] w);
        applyStimulus(w[15:8]);
        applyStimulus(w[7:0]);
    endtask

    task automatic readCheck(input string tag, input int addr, input logic [31:0] exp);
        bus.rd_addr = AW'(addr);
        #1;
        checkOutput(tag, 32'(bus.rd_data), exp);
    endtask

    task automatic pulseStart();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic pulseAbort();
        bus.load_abort = 1'b1;
        tick();
        bus.load_abort = 1'b0;
    endtask

    task automatic pulseClear();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic bsy, input logic done, input int wc);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
        checkOutput({tag, "_ready"}, 32'(bus.byte_ready), 32'(bsy));
        checkOutput({tag, "_done"}, 32'(bus.load_done), 32'(done));
        checkOutput({tag, "_wc"}, 32'(bus.word_count), 32'(wc));
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_abort = 1'b0;
        bus.clear_req  = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        bus.rd_addr    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        checkStatus("rst", 1'b0, 1'b0, 0);
        for (int i = 0; i < DP; i++) readCheck("rst_mem", i, 32'h0);
        readCheck("rst_oob", 40, 32'h0);

        // Full load, word i = i
        pulseStart();
        checkStatus("t2_start", 1'b1, 1'b0, 0);
        for (int i = 0; i < DP - 1; i++) sendWord(16'(i));
        applyStimulus(8'h00);
        checkStatus("t2_pre_last", 1'b1, 1'b0, 31);
        applyStimulus(8'd31);
        checkStatus("t2_end", 1'b0, 1'b1, 32);
        for (int i = 0; i < DP; i++) readCheck("t2_mem", i, 32'(i));
        readCheck("t2_oob", 40, 32'h0);
        applyStimulus(8'hFF);
        applyStimulus(8'hEE);
        checkStatus("t2_ignored", 1'b0, 1'b1, 32);
        readCheck("t2_ignored_mem0", 0, 32'h0);

        // Stall between hi and lo bytes of word 3
        pulseStart();
        checkStatus("t3_start", 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) sendWord(16'(i));
        applyStimulus(8'hA5);
        repeat (5) tick();
        checkStatus("t3_stall", 1'b1, 1'b0, 3);
        bus.byte_data  = 8'h5A;
        bus.byte_valid = 1'b1;
        readCheck("t3_old_value", 3, 32'h3);
        tick();
        bus.byte_valid = 1'b0;
        readCheck("t3_new_value", 3, 32'hA55A);
        checkOutput("t3_wc4", 32'(bus.word_count), 32'd4);
        for (int i = 4; i < DP; i++) sendWord(16'(i));
        checkStatus("t3_end", 1'b0, 1'b1, 32);
        readCheck("t3_mem3", 3, 32'hA55A);
        readCheck("t3_mem4", 4, 32'h4);
        readCheck("t3_mem2", 2, 32'h2);

        // Abort with a partial word pending
        pulseStart();
        sendWord(16'h1234);
        sendWord(16'hBEEF);
        applyStimulus(8'h77);
        pulseAbort();
        checkStatus("t4_abort", 1'b0, 1'b0, 2);
        readCheck("t4_mem0", 0, 32'h1234);
        readCheck("t4_mem1", 1, 32'hBEEF);
        readCheck("t4_mem2", 2, 32'h2);
        pulseAbort();
        applyStimulus(8'h11);
        checkStatus("t4_idle", 1'b0, 1'b0, 2);
        readCheck("t4_idle_mem2", 2, 32'h2);
        pulseStart();
        sendWord(16'hABCD);
        readCheck("t4_restart_mem0", 0, 32'hABCD);

        // Priority: restart beats byte accept at waddr 7
        for (int k = 1; k < 7; k++) sendWord(16'h0100 + 16'(k));
        bus.load_start = 1'b1;
        bus.byte_data  = 8'h99;
        bus.byte_valid = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        checkStatus("t5_restart", 1'b1, 1'b0, 0);
        sendWord(16'h5566);
        readCheck("t5_mem0", 0, 32'h5566);
        readCheck("t5_mem1", 1, 32'h0101);
        readCheck("t5_mem7", 7, 32'h7);
        checkOutput("t5_wc1", 32'(bus.word_count), 32'd1);
        bus.load_abort = 1'b1;
        bus.load_start = 1'b1;
        tick();
        bus.load_abort = 1'b0;
        bus.load_start = 1'b0;
        checkStatus("t5_abort_start", 1'b0, 1'b0, 1);

        // Clear in DONE, clear ignored in LOAD, clear with start
        pulseStart();
        for (int i = 0; i < DP; i++) sendWord(16'hC000 | 16'(i));
        checkStatus("t6_full", 1'b0, 1'b1, 32);
        readCheck("t6_full_mem5", 5, 32'hC005);
        pulseClear();
        checkStatus("t6_clear", 1'b0, 1'b0, 0);
        for (int i = 0; i < DP; i++) readCheck("t6_clear_mem", i, 32'h0);
        pulseStart();
        sendWord(16'h1357);
        sendWord(16'h2468);
        pulseClear();
        checkStatus("t6_clear_in_load", 1'b1, 1'b0, 2);
        readCheck("t6_keep_mem0", 0, 32'h1357);
        readCheck("t6_keep_mem1", 1, 32'h2468);
        pulseAbort();
        bus.clear_req  = 1'b1;
        bus.load_start = 1'b1;
        tick();
        bus.clear_req  = 1'b0;
        bus.load_start = 1'b0;
        checkStatus("t6_clear_start", 1'b1, 1'b0, 0);
        readCheck("t6_cs_mem0", 0, 32'h0);
        readCheck("t6_cs_mem1", 1, 32'h0);

        // Asynchronous reset in the middle of a load
        sendWord(16'h4242);
        applyStimulus(8'h99);
        checkOutput("t6_pre_rst_wc", 32'(bus.word_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkStatus("t6_async_rst", 1'b0, 1'b0, 0);
        readCheck("t6_async_rst_mem0", 0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkStatus("t6_after_rst", 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
